// File: rtl/cheshire_xilinx_pkg.sv
// Shared types for the Xilinx-target reset sequencer.
// Latency/backpressure: not applicable (types and helpers only).
package cheshire_xilinx_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        DRAM_RST,
        WAIT_CALIB,
        HOLD,
        RUN,
        FAIL
    } rst_state_e;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cheshire_rst_seq_xilinx_if.sv
// Board-side reset inputs and SoC/DRAM reset outputs of the reset sequencer.
// Latency/backpressure: plain level signals, no handshake.
interface cheshire_rst_seq_xilinx_if;
    logic       clk_locked_i;
    logic       btn_reset_i;
    logic       vio_reset_i;
    logic       dram_calib_done_i;
    logic [1:0] boot_mode_i;
    logic       soc_rst_no;
    logic       dram_rst_o;
    logic [1:0] boot_mode_o;
    logic       fail_o;

    modport master (
        output clk_locked_i, btn_reset_i, vio_reset_i, dram_calib_done_i, boot_mode_i,
        input  soc_rst_no, dram_rst_o, boot_mode_o, fail_o
    );

    modport slave (
        input  clk_locked_i, btn_reset_i, vio_reset_i, dram_calib_done_i, boot_mode_i,
        output soc_rst_no, dram_rst_o, boot_mode_o, fail_o
    );
endinterface

// File: rtl/cheshire_debounce.sv
// Level debouncer: output follows the input after Cycles consecutive mismatching cycles.
// Latency: Cycles cycles from a stable change; no backpressure.
module cheshire_debounce #(
    parameter int unsigned Cycles = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    localparam int unsigned CntW = $clog2(Cycles + 1);

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            val_d, val_q;

    // Any cycle where input equals output restarts the mismatch count.
    always_comb begin
        cnt_d = '0;
        val_d = val_q;
        if (d_i != val_q) begin
            if (cnt_q >= CntW'(Cycles - 1)) val_d = d_i;
            else                            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            val_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            val_q <= val_d;
        end
    end

    assign q_o = val_q;
endmodule

// File: rtl/sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// Latency: STAGES cycles; no backpressure.
module sync #(
    parameter int unsigned STAGES     = 2,
    parameter bit          ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);
    logic [STAGES-1:0] reg_d, reg_q;

    always_comb begin
        reg_d = {reg_q[STAGES-2:0], serial_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) reg_q <= {STAGES{ResetValue}};
        else         reg_q <= reg_d;
    end

    assign serial_o = reg_q[STAGES-1];
endmodule

// File: rtl/cheshire_rst_seq_xilinx.sv
// Board reset sequencer: lock -> DRAM reset -> calibration -> hold -> SoC run, with FAIL on timeout.
// Latency: inputs pass 2-flop sync (+ debounce for button) + 1 FSM edge; no backpressure.
module cheshire_rst_seq_xilinx
    import cheshire_xilinx_pkg::*;
#(
    parameter int unsigned DebounceCycles     = 50000,
    parameter int unsigned DramRstCycles      = 16,
    parameter int unsigned CalibTimeoutCycles = 2**24,
    parameter int unsigned HoldCycles         = 64,
    parameter bit          UseDram            = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    cheshire_rst_seq_xilinx_if.slave  io
);
    localparam int unsigned MaxCnt = max3(DramRstCycles, CalibTimeoutCycles, HoldCycles);
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

    localparam logic [CntW-1:0] DramLast  = CntW'(DramRstCycles - 1);
    localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeoutCycles - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);

    logic lock_sync, calib_sync, btn_sync, btn_deb, req;

    sync #(.STAGES(2), .ResetValue(1'b0)) i_sync_lock (
        .clk_i, .rst_ni, .serial_i(io.clk_locked_i), .serial_o(lock_sync)
    );
    sync #(.STAGES(2), .ResetValue(1'b0)) i_sync_calib (
        .clk_i, .rst_ni, .serial_i(io.dram_calib_done_i), .serial_o(calib_sync)
    );
    sync #(.STAGES(2), .ResetValue(1'b0)) i_sync_btn (
        .clk_i, .rst_ni, .serial_i(io.btn_reset_i), .serial_o(btn_sync)
    );

    cheshire_debounce #(.Cycles(DebounceCycles)) i_debounce (
        .clk_i, .rst_ni, .d_i(btn_sync), .q_o(btn_deb)
    );

    assign req = btn_deb | io.vio_reset_i | ~lock_sync;

    rst_state_e      state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            soc_rst_n_d, soc_rst_n_q;
    logic            dram_rst_d, dram_rst_q;
    logic            fail_d, fail_q;
    logic [1:0]      boot_mode_d, boot_mode_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_LOCK:  state_d = UseDram ? DRAM_RST : HOLD;
            DRAM_RST:   if (cnt_q >= DramLast) state_d = WAIT_CALIB;
            WAIT_CALIB: begin
                // Calibration wins over a coincident timeout.
                if (calib_sync)              state_d = HOLD;
                else if (cnt_q >= CalibLast) state_d = FAIL;
            end
            HOLD:       if (cnt_q >= HoldLast) state_d = RUN;
            RUN, FAIL:  state_d = state_q;
            default:    state_d = WAIT_LOCK;
        endcase
        if (req) state_d = WAIT_LOCK;

        cnt_d = '0;
        if ((state_d == state_q) && (state_q inside {DRAM_RST, WAIT_CALIB, HOLD}))
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);

        soc_rst_n_d = (state_d == RUN);
        dram_rst_d  = (state_d inside {WAIT_LOCK, DRAM_RST});
        fail_d      = (state_d == FAIL);
        boot_mode_d = ((state_d == RUN) && (state_q != RUN)) ? io.boot_mode_i : boot_mode_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            soc_rst_n_q <= 1'b0;
            dram_rst_q  <= 1'b1;
            fail_q      <= 1'b0;
            boot_mode_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            soc_rst_n_q <= soc_rst_n_d;
            dram_rst_q  <= dram_rst_d;
            fail_q      <= fail_d;
            boot_mode_q <= boot_mode_d;
        end
    end

    assign io.soc_rst_no  = soc_rst_n_q;
    assign io.dram_rst_o  = dram_rst_q;
    assign io.fail_o      = fail_q;
    assign io.boot_mode_o = boot_mode_q;
endmodule
